dec2bin: RTL and testbench
==========================

Name: dec2bin

Overview:
- Converts a packed BCD number (most-significant digit first) into an unsigned binary value.
- It is the reverse of the divide-by-10 binary-to-decimal path.
- Uses one multiply-by-10-and-add step per clock, computed with shift-add only (no divider or multiplier IP).
- Sits between keypad/display-side decimal data and the binary measurement/control datapath, with valid/ready handshakes on both sides.

Parameters:
- NUM_DIGITS, 10, number of BCD digits accepted per conversion (>=1).
- WIDTH, 32, width of the binary result.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit NUM_DIGITS-1 (MSD) in the top nibble, digit 0 (LSD) in bits [3:0].
- in_valid  input  1  bcd_in valid.
- in_ready  output  1  block can accept a new number.
- bin_out  output  WIDTH  binary result, low WIDTH bits of the decimal value.
- out_valid  output  1  bin_out/overflow/bad_digit valid.
- out_ready  input  1  consumer accepts the result.
- overflow  output  1  decimal value >= 2^WIDTH.
- bad_digit  output  1  at least one nibble of the captured number > 9.
- busy  output  1  conversion in progress (state CONV).

Behaviour:
Reset:
- rst_n low forces state IDLE asynchronously, whatever the current state.
- Reset values: in_ready=1, out_valid=0, busy=0, bin_out=0, overflow=0, bad_digit=0.
- The internal accumulator, shift register and digit counter are cleared.
- Reset mid-conversion discards the conversion; no partial result is ever presented.

States: IDLE, CONV, DONE (registered FSM).

IDLE:
- in_ready=1.
- On in_valid & in_ready at edge E0:
  - capture bcd_in into the digit shift register;
  - acc=0, cnt=0, overflow=0, bad_digit=0;
  - move to CONV.

CONV:
- in_ready=0, busy=1.
- Each edge:
  - d = top nibble of the shift register;
  - next = acc*10 + d, computed as (acc<<3)+(acc<<1)+d in WIDTH+4 bits;
  - acc <= next[WIDTH-1:0];
  - overflow <= overflow | (next[WIDTH+3:WIDTH] != 0);
  - bad_digit <= bad_digit | (d > 9);
  - shift register shifts left by one nibble; cnt++.
- A digit > 9 is still used arithmetically at its raw value (0xA counts as 10).
- At the edge that processes digit 0 (edge E_NUM_DIGITS), move to DONE and register bin_out from next.

DONE:
- out_valid=1; bin_out, overflow and bad_digit are held stable.
- On out_valid & out_ready, return to IDLE: out_valid=0, in_ready=1 on the next cycle.
- bin_out keeps its last value after the handshake.

Timing and handshake rules:
- Latency: out_valid rises exactly NUM_DIGITS cycles after the accept edge.
- Throughput: one conversion per NUM_DIGITS+2 cycles with out_ready held high.
- No input/output overlap: in_ready=0 throughout CONV and DONE.
- in_valid while not ready is ignored; bcd_in is not sampled.
- out_ready while out_valid=0 has no effect.
- Overflow saturates nothing: bin_out is the value modulo 2^WIDTH.

Test Plan:
- Reset, then bcd_in=0x0003932257 with in_valid one cycle, out_ready=1 -> out_valid rises 10 cycles after accept; bin_out=0x003C0061, overflow=0, bad_digit=0, out_valid high 1 cycle.
- bcd_in=0x4294967295 -> bin_out=0xFFFFFFFF, overflow=0; then bcd_in=0x4294967296 -> bin_out=0x00000000, overflow=1; then bcd_in=0x9999999999 -> bin_out=0x540BE3FF, overflow=1.
- bcd_in=0x0000000000 -> bin_out=0, flags 0. Then bcd_in=0x000000000A -> bin_out=10, bad_digit=1, overflow=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> bin_out, flags and out_valid stable; in_ready=0; in_valid pulses ignored. out_ready=1 -> out_valid falls next cycle, in_ready=1.
- Assert rst_n=0 at the 4th CONV cycle -> all outputs at reset values immediately. Release and convert 0x0000000123 -> bin_out=0x0000007B with no contamination from the aborted conversion.
- Back-to-back: in_valid held high with 3 different values, out_ready=1 -> three results in order, each NUM_DIGITS+2 cycles apart.

Source files
------------

// File: rtl/dec2bin.sv
// Packed BCD to binary converter: one multiply-by-10-and-add per clock,
// built from shifts and adds, with valid/ready handshakes on both sides.
module dec2bin #(
  parameter int NUM_DIGITS = 10,
  parameter int WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        bin_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    bad_digit,
  output logic                    busy
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [SW-1:0]    sr_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             bad_q;
  logic [WIDTH-1:0] bin_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       dig_d;
  logic [WIDTH+3:0] ext_d;
  logic [WIDTH+3:0] nxt_d;
  logic             ovf_d;
  logic             bad_d;

  // acc*10 + d as (acc<<3)+(acc<<1)+d, four guard bits catch overflow
  always_comb begin
    dig_d = sr_q[SW-1 -: 4];
    ext_d = {4'b0, acc_q};
    nxt_d = (ext_d << 3) + (ext_d << 1) + {{WIDTH{1'b0}}, dig_d};
    ovf_d = ovf_q | (nxt_d[WIDTH+3:WIDTH] != 4'd0);
    bad_d = bad_q | (dig_d > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      bin_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= CONV;
            sr_q       <= bcd_in;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bad_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CONV: begin
          acc_q <= nxt_d[WIDTH-1:0];
          ovf_q <= ovf_d;
          bad_q <= bad_d;
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            bin_q       <= nxt_d[WIDTH-1:0];
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bin_out   = bin_q;
  assign overflow  = ovf_q;
  assign bad_digit = bad_q;

endmodule

// File: tb/tb_dec2bin.sv
// Directed bench for dec2bin: conversions, flags, backpressure,
// mid-conversion reset and back-to-back throughput.
module tb_dec2bin;

  localparam int N = 10;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [4*N-1:0] bcd_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] bin_out;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic         bad_digit;
  logic         busy;

  int total;
  int bad;
  int cyc;

  dec2bin #(.NUM_DIGITS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .bad_digit (bad_digit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic convert(input logic [4*N-1:0] v, input logic [W-1:0] eb,
                         input logic eo, input logic eb_flag, input string tag);
    int n;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    bcd_in   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bcd_in   = '0;
    chk({tag, "_busy"}, {62'd0, busy, in_ready}, 64'b10);
    wait_out(n);
    chk({tag, "_lat"}, 64'(n), 64'(N));
    chk({tag, "_bin"}, 64'(bin_out), 64'(eb));
    chk({tag, "_flags"}, {62'd0, overflow, bad_digit}, {62'd0, eo, eb_flag});
    tick();
    chk({tag, "_rel"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int n;
    int t[3];
    logic [4*N-1:0] vals[3];
    logic [W-1:0]   exps[3];
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bcd_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_ctl", {61'd0, out_valid, busy, overflow}, 64'd0);
    chk("rst_bin", {31'd0, bad_digit, bin_out}, 64'd0);
    rst_n = 1'b1;
    tick();

    convert(40'h0003932257, 32'h003C0061, 1'b0, 1'b0, "c3932257");
    convert(40'h4294967295, 32'hFFFFFFFF, 1'b0, 1'b0, "cmax");
    convert(40'h4294967296, 32'h00000000, 1'b1, 1'b0, "cwrap");
    convert(40'h9999999999, 32'h540BE3FF, 1'b1, 1'b0, "cnines");
    convert(40'h0000000000, 32'h00000000, 1'b0, 1'b0, "czero");
    convert(40'h000000000A, 32'h0000000A, 1'b0, 1'b1, "cbad");

    // backpressure with ignored input pulses
    out_ready = 1'b0;
    bcd_in    = 40'h0000001234;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    wait_out(n);
    chk("bp_lat", 64'(n), 64'(N));
    for (int i = 0; i < 5; i++) begin
      bcd_in   = 40'h0000000777;
      in_valid = (i % 2) == 0;
      tick();
      chk("bp_hold", {29'd0, out_valid, in_ready, overflow, bad_digit, bin_out},
          {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000004D2});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel", {30'd0, out_valid, in_ready, bin_out},
        {30'd0, 1'b0, 1'b1, 32'h000004D2});

    // reset in the 4th CONV cycle
    bcd_in   = 40'h9999999999;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {60'd0, in_ready, out_valid, busy, overflow}, 64'b1000);
    chk("abort_bin", {31'd0, bad_digit, bin_out}, 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    convert(40'h0000000123, 32'h0000007B, 1'b0, 1'b0, "after_rst");

    // back-to-back with in_valid held
    vals[0] = 40'h0000000042; exps[0] = 32'h0000002A;
    vals[1] = 40'h0000065535; exps[1] = 32'h0000FFFF;
    vals[2] = 40'h1000000000; exps[2] = 32'h3B9ACA00;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      bcd_in = vals[k];
      chk("b2b_rdy", 64'(in_ready), 64'd1);
      tick();
      wait_out(n);
      t[k] = cyc;
      chk("b2b_bin", 64'(bin_out), 64'(exps[k]));
    end
    in_valid = 1'b0;
    chk("b2b_gap1", 64'(t[1] - t[0]), 64'(N + 2));
    chk("b2b_gap2", 64'(t[2] - t[1]), 64'(N + 2));
    tick();
    chk("b2b_end", {62'd0, out_valid, in_ready}, 64'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
